// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle control FSM for the R-type MIPS ALU datapath (fetch/decode/execute/writeback).
// Define MIPS_CTRL_SINGLE_STEP_EN to add a 'step' input that runs one instruction from IDLE.
module mips_multicycle_ctrl #(
    parameter int unsigned FETCH_TIMEOUT = 15,
    parameter int unsigned CNT_W         = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [31:0]      INSTRUCTION,
    input  logic             mem_ready,
    input  logic             run,
`ifdef MIPS_CTRL_SINGLE_STEP_EN
    input  logic             step,
`endif
    output logic             pc_write,
    output logic             ir_write,
    output logic             reg_write,
    output logic [3:0]       alu_ctrl,
    output logic [2:0]       state,
    output logic             illegal,
    output logic             timeout,
    output logic             halted,
    output logic [CNT_W-1:0] retired,
    output logic [CNT_W-1:0] illegal_cnt
);

    localparam int unsigned WAIT_W = (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALT      = 3'd5
    } state_t;

    state_t            cur;
    logic [31:0]       ir_q;
    logic [WAIT_W-1:0] wait_cnt;
    logic              go;
    logic              funct_ok;
    logic [3:0]        funct_alu;
    logic              unused_ir;

    assign state     = cur;
    assign unused_ir = ^{ir_q[25:16], ir_q[10:6]};

`ifdef MIPS_CTRL_SINGLE_STEP_EN
    // A step pulse only leaves IDLE; completion returns to IDLE whenever run is low.
    assign go = run | step;
`else
    assign go = run;
`endif

    always_comb begin
        funct_ok  = 1'b1;
        funct_alu = 4'b0010;
        unique case (ir_q[5:0])
            6'h20:   funct_alu = 4'b0010;
            6'h22:   funct_alu = 4'b0110;
            6'h24:   funct_alu = 4'b0000;
            6'h25:   funct_alu = 4'b0001;
            6'h27:   funct_alu = 4'b1100;
            6'h2A:   funct_alu = 4'b0111;
            default: funct_ok  = 1'b0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            cur         <= S_IDLE;
            ir_q        <= '0;
            wait_cnt    <= '0;
            pc_write    <= 1'b0;
            ir_write    <= 1'b0;
            reg_write   <= 1'b0;
            illegal     <= 1'b0;
            alu_ctrl    <= 4'b0010;
            timeout     <= 1'b0;
            halted      <= 1'b0;
            retired     <= '0;
            illegal_cnt <= '0;
        end else begin
            pc_write  <= 1'b0;
            ir_write  <= 1'b0;
            reg_write <= 1'b0;
            illegal   <= 1'b0;
            case (cur)
                S_IDLE: begin
                    wait_cnt <= '0;
                    if (go) cur <= S_FETCH;
                end
                S_FETCH: begin
                    if (mem_ready) begin
                        pc_write <= 1'b1;
                        ir_write <= 1'b1;
                        ir_q     <= INSTRUCTION;
                        wait_cnt <= '0;
                        cur      <= S_DECODE;
                    end else if (wait_cnt == WAIT_W'(FETCH_TIMEOUT - 1)) begin
                        timeout <= 1'b1;
                        halted  <= 1'b1;
                        cur     <= S_HALT;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                S_DECODE: begin
                    if (ir_q[31:26] == 6'h3F) begin
                        halted <= 1'b1;
                        cur    <= S_HALT;
                    end else if (ir_q[31:26] == 6'h00 && funct_ok) begin
                        alu_ctrl <= funct_alu;
                        cur      <= S_EXECUTE;
                    end else begin
                        illegal <= 1'b1;
                        if (illegal_cnt != '1) illegal_cnt <= illegal_cnt + CNT_W'(1);
                        cur <= run ? S_FETCH : S_IDLE;
                    end
                end
                S_EXECUTE: cur <= S_WRITEBACK;
                S_WRITEBACK: begin
                    reg_write <= (ir_q[15:11] != 5'd0);
                    if (retired != '1) retired <= retired + CNT_W'(1);
                    cur <= run ? S_FETCH : S_IDLE;
                end
                S_HALT: halted <= 1'b1;
                default: cur <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench for mips_multicycle_ctrl: random programs checked against an instruction-level model.
module tb_mips_multicycle_ctrl;

    localparam int CNT_W = 16;

    logic             CLK = 1'b0;
    logic             RESET;
    logic [31:0]      INSTRUCTION;
    logic             mem_ready;
    logic             run;
    logic             pc_write, ir_write, reg_write, illegal, timeout, halted;
    logic [3:0]       alu_ctrl;
    logic [2:0]       state;
    logic [CNT_W-1:0] retired, illegal_cnt;

    always #5 CLK = ~CLK;

    mips_multicycle_ctrl #(.FETCH_TIMEOUT(15), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RESET(RESET), .INSTRUCTION(INSTRUCTION), .mem_ready(mem_ready), .run(run),
        .pc_write(pc_write), .ir_write(ir_write), .reg_write(reg_write), .alu_ctrl(alu_ctrl),
        .state(state), .illegal(illegal), .timeout(timeout), .halted(halted),
        .retired(retired), .illegal_cnt(illegal_cnt)
    );

    typedef struct packed {
        logic [1:0] kind;   // 0 retire, 1 illegal, 2 halt
        logic [3:0] alu;
        logic       wr;
    } exp_t;

    localparam logic [5:0] FUNCT_TAB [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};
    localparam logic [3:0] ALU_TAB   [6] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b1100, 4'b0111};

    exp_t        sbq[$];
    logic [31:0] prog[$];
    int unsigned pidx;
    int unsigned pass_cnt = 0, total_cnt = 0;
    bit          mon_en = 0;
    int unsigned m_ret = 0, m_ill = 0;
    bit          halt_seen = 0;
    logic [CNT_W-1:0] prev_ret = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic exp_t ref_model(input logic [31:0] w);
        exp_t e;
        e.kind = 2'd1;
        e.alu  = 4'b0010;
        e.wr   = 1'b0;
        if (w[31:26] == 6'h3F) e.kind = 2'd2;
        else if (w[31:26] == 6'h00)
            for (int i = 0; i < 6; i++)
                if (w[5:0] == FUNCT_TAB[i]) begin
                    e.kind = 2'd0;
                    e.alu  = ALU_TAB[i];
                end
        e.wr = (e.kind == 2'd0) && (w[15:11] != 5'd0);
        return e;
    endfunction

    function automatic bit legal_funct(input logic [5:0] f);
        for (int i = 0; i < 6; i++) if (f == FUNCT_TAB[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [5:0]  f;
        int unsigned r;
        r = $urandom_range(0, 99);
        w = $urandom;
        if (r < 70) begin
            w[31:26] = 6'h00;
            w[5:0]   = FUNCT_TAB[$urandom_range(0, 5)];
            if ($urandom_range(0, 4) == 0) w[15:11] = 5'd0;
        end else if (r < 85) begin
            w[31:26] = 6'h00;
            do f = 6'($urandom_range(0, 63)); while (legal_funct(f));
            w[5:0] = f;
        end else begin
            w[31:26] = 6'($urandom_range(1, 62));
        end
        return w;
    endfunction

    function automatic logic [31:0] cur_word();
        return (pidx < prog.size()) ? prog[pidx] : 32'hFC00_0000;
    endfunction

    // Instruction memory: the word at pidx is served; a pc_write advances pidx and queues its expectation.
    task automatic tick();
        @(negedge CLK);
        if (pc_write) begin
            sbq.push_back(ref_model(cur_word()));
            pidx++;
        end
        INSTRUCTION = cur_word();
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string nm);
        int n = 0;
        while (state != s && n < budget) begin tick(); n++; end
        if (state != s) chk(nm, {29'd0, state}, {29'd0, s});
    endtask

    task automatic start_reset(input int cycles);
        mon_en = 0;
        RESET  = 1'b1;
        repeat (cycles) tick();
        sbq.delete();
    endtask

    // Monitor: pops one expectation per completion event the DUT presents.
    always @(negedge CLK) begin
        exp_t e;
        if (!mon_en) begin
            m_ret = 0; m_ill = 0; halt_seen = 0;
        end else begin
            chk("pulse_exclusive", {30'd0, (pc_write | ir_write) & reg_write, pc_write ^ ir_write}, 32'd0);
            if (retired != prev_ret) begin
                m_ret++;
                if (sbq.size() == 0) chk("sb_underflow_retire", 1, 0);
                else begin
                    e = sbq.pop_front();
                    chk("retire_kind", {30'd0, e.kind}, 32'd0);
                    chk("alu_ctrl", {28'd0, alu_ctrl}, {28'd0, e.alu});
                    chk("reg_write", {31'd0, reg_write}, {31'd0, e.wr});
                    chk("retired_cnt", {16'd0, retired}, m_ret);
                end
            end else if (reg_write) chk("stray_reg_write", 1, 0);
            if (illegal) begin
                m_ill++;
                if (sbq.size() == 0) chk("sb_underflow_illegal", 1, 0);
                else begin
                    e = sbq.pop_front();
                    chk("illegal_kind", {30'd0, e.kind}, 32'd1);
                    chk("illegal_no_regwr", {31'd0, reg_write}, 32'd0);
                    chk("illegal_cnt", {16'd0, illegal_cnt}, m_ill);
                end
            end
            if (state == 3'd5 && !halt_seen) begin
                halt_seen = 1;
                if (sbq.size() == 0) chk("sb_underflow_halt", 1, 0);
                else begin
                    e = sbq.pop_front();
                    chk("halt_kind", {30'd0, e.kind}, 32'd2);
                    chk("halted_flag", {31'd0, halted}, 32'd1);
                end
            end
        end
        prev_ret = retired;
    end

    initial begin
        int n;
        int stall;
        int nonhalt;
        RESET = 1'b1; run = 1'b0; mem_ready = 1'b0; INSTRUCTION = '0; pidx = 0;

        // Directed prefix: ADD rd=2, AND, OR, SUB, SLT, NOR, ADD rd=0, funct 3E; then random; then HALT.
        prog = '{32'h0000_1020, 32'h0000_1824, 32'h0000_2025, 32'h0000_2822,
                 32'h0000_302A, 32'h0000_3827, 32'h0000_0020, 32'h0000_103E};
        repeat (60) prog.push_back(rand_instr());
        prog.push_back(32'hFC00_0000 | ($urandom & 32'h03FF_FFFF));
        nonhalt = prog.size() - 1;

        start_reset(2);
        chk("rst_state", {29'd0, state}, 32'd0);
        chk("rst_alu", {28'd0, alu_ctrl}, 32'd2);
        chk("rst_pulses", {28'd0, pc_write, ir_write, reg_write, illegal}, 32'd0);
        chk("rst_flags", {30'd0, timeout, halted}, 32'd0);
        chk("rst_counters", {retired, illegal_cnt}, 32'd0);

        pidx = 0; INSTRUCTION = cur_word();
        RESET = 1'b0; run = 1'b1; mem_ready = 1'b1; mon_en = 1;
        tick();
        chk("lat_edge1_pc_write", {31'd0, pc_write}, 32'd0);
        chk("lat_edge1_fetch", {29'd0, state}, 32'd1);
        tick();
        chk("lat_edge2_pc_write", {31'd0, pc_write}, 32'd1);
        chk("lat_edge2_decode", {29'd0, state}, 32'd2);
        repeat (3) tick();
        chk("cpi_gap_pc_write", {31'd0, pc_write}, 32'd0);
        tick();
        chk("cpi4_pc_write", {31'd0, pc_write}, 32'd1);

        // Random phase: stalls capped well below the timeout, run occasionally dropped.
        stall = 0; n = 0;
        while (!halted && n < 6000) begin
            if (pidx < 8) mem_ready = 1'b1;
            else if (stall > 0) begin stall--; mem_ready = (stall == 0); end
            else if ($urandom_range(0, 3) == 0) begin stall = $urandom_range(2, 9); mem_ready = 1'b0; end
            else mem_ready = 1'b1;
            run = (pidx < 8) ? 1'b1 : ($urandom_range(0, 7) != 0);
            tick();
            n++;
        end
        chk("halt_reached", {31'd0, halted}, 32'd1);
        repeat (6) begin
            run = ~run; mem_ready = $urandom_range(0, 1) != 0;
            tick();
            chk("halt_sticky", {29'd0, state}, 32'd5);
            chk("halt_no_pulse", {29'd0, pc_write, reg_write, illegal}, 32'd0);
        end
        chk("sb_drained", sbq.size(), 0);
        chk("total_done", retired + illegal_cnt, nonhalt);
        chk("final_retired", {16'd0, retired}, m_ret);
        chk("final_illegal", {16'd0, illegal_cnt}, m_ill);

        // Fetch timeout: exactly 15 starved FETCH cycles end in HALT.
        start_reset(2);
        RESET = 1'b0; run = 1'b1; mem_ready = 1'b0;
        tick();
        chk("to_enter_fetch", {29'd0, state}, 32'd1);
        repeat (14) tick();
        chk("to_14_still_fetch", {29'd0, state}, 32'd1);
        chk("to_14_no_timeout", {31'd0, timeout}, 32'd0);
        tick();
        chk("to_15_halt", {29'd0, state}, 32'd5);
        chk("to_15_timeout", {30'd0, timeout, halted}, 32'd3);
        mem_ready = 1'b1; run = 1'b0;
        repeat (3) tick();
        chk("to_timeout_sticky", {29'd0, state, timeout}, {28'd0, 3'd5, 1'b1});
        RESET = 1'b1;
        tick();
        chk("to_reset_idle", {29'd0, state}, 32'd0);
        chk("to_reset_clear", {30'd0, timeout, halted}, 32'd0);

        // Reset in the middle of EXECUTE clears counters.
        sbq.delete();
        prog = '{32'h0000_003E, 32'h0000_2820, 32'h0000_3022};
        pidx = 0; INSTRUCTION = cur_word();
        RESET = 1'b0; run = 1'b1; mem_ready = 1'b1; mon_en = 1;
        n = 0;
        while (retired == 0 && n < 40) begin tick(); n++; end
        chk("mid_first_retire", {16'd0, retired}, 32'd1);
        wait_state(3'd3, 20, "mid_reach_execute");
        chk("mid_illegal_seen", {16'd0, illegal_cnt}, 32'd1);
        start_reset(1);
        chk("mid_rst_state", {29'd0, state}, 32'd0);
        chk("mid_rst_counters", {retired, illegal_cnt}, 32'd0);
        chk("mid_rst_alu", {28'd0, alu_ctrl}, 32'd2);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
